// File: rtl/mem_block_if.sv
// Cache-controller <-> main-memory block request interface.
// The controller drives the master side; the memory responder sits on the slave side.
interface mem_block_if #(
    parameter int PA_WIDTH  = 32,
    parameter int MEM_WIDTH = 128
);
    logic [PA_WIDTH-1:0]  mem_addr;
    logic                 mem_rd_en;
    logic                 mem_wr_en;
    logic [MEM_WIDTH-1:0] mem_wr_blk;
    logic [MEM_WIDTH-1:0] mem_rd_blk;
    logic                 mem_ready;
    logic                 mem_busy;
    logic                 mem_err;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk,
        input  mem_rd_blk, mem_ready, mem_busy, mem_err
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk,
        output mem_rd_blk, mem_ready, mem_busy, mem_err
    );
endinterface

// File: rtl/mem_block_responder.sv
// Main-memory block responder: serves one block read/write per request after LATENCY cycles.
// Define MEM_INIT_PATTERN_EN to preload block i with {MEM_WIDTH/32{i}}; otherwise the array starts as X.
//
// state  | meaning
// S_IDLE | waiting for mem_rd_en / mem_wr_en
// S_BUSY | request latched, latency counter running down
// S_DONE | one-cycle completion, mem_ready high
module mem_block_responder #(
    parameter int PA_WIDTH  = 32,
    parameter int MEM_WIDTH = 128,
    parameter int IDX_BITS  = 10,
    parameter int LATENCY   = 4
) (
    input logic        clk,
    input logic        rst_n,
    mem_block_if.slave bus
);
    localparam int OFF   = $clog2(MEM_WIDTH / 8);
    localparam int DEPTH = 2 ** IDX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef logic [MEM_WIDTH-1:0] mem_array_t [DEPTH];

`ifdef MEM_INIT_PATTERN_EN
    function automatic mem_array_t init_pattern();
        mem_array_t arr;
        logic [31:0] word;
        for (int i = 0; i < DEPTH; i++) begin
            word   = 32'(i);
            arr[i] = {(MEM_WIDTH / 32){word}};
        end
        return arr;
    endfunction

    mem_array_t mem_array = init_pattern();
`else
    mem_array_t mem_array;
`endif

    state_t               state_q, state_d;
    logic [7:0]           cnt_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic [MEM_WIDTH-1:0] wr_blk_q;
    logic                 is_wr_q;
    logic                 err_q;
    logic [MEM_WIDTH-1:0] rd_blk_q;
    logic                 accept;
    logic                 complete;
    logic                 ready_d;
    logic                 busy_d;

    // Offset bits and bits above the index are don't-care: addresses alias on the block index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[PA_WIDTH-1:OFF+IDX_BITS], bus.mem_addr[OFF-1:0]};

    assign accept   = (state_q == S_IDLE) && (bus.mem_rd_en || bus.mem_wr_en);
    assign complete = (state_q == S_BUSY) && (cnt_q == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: begin
                busy_d = 1'b1;
                if (cnt_q == 8'd0) state_d = S_DONE;
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 8'd0;
            idx_q    <= '0;
            wr_blk_q <= '0;
            is_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_blk_q <= '0;
        end else begin
            if (accept) begin
                idx_q    <= bus.mem_addr[OFF+IDX_BITS-1:OFF];
                wr_blk_q <= bus.mem_wr_blk;
                // A simultaneous read+write is served as a write; the read is dropped.
                is_wr_q  <= bus.mem_wr_en;
                cnt_q    <= 8'(LATENCY - 1);
                if (bus.mem_rd_en && bus.mem_wr_en) err_q <= 1'b1;
            end else if (state_q == S_BUSY && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (complete && !is_wr_q) rd_blk_q <= mem_array[idx_q];
        end
    end

    // Array is never reset; a request cut short by reset never reaches the commit edge.
    always_ff @(posedge clk) begin
        if (complete && is_wr_q) mem_array[idx_q] <= wr_blk_q;
    end

    assign bus.mem_ready  = ready_d;
    assign bus.mem_busy   = busy_d;
    assign bus.mem_err    = err_q;
    assign bus.mem_rd_blk = rd_blk_q;
endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder: requests push expectations, a monitor checks ready pulses.
module tb_mem_block_responder;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int unsigned acc_cyc;
        bit          is_rd;
        logic [127:0] data;
    } exp_t;
    exp_t sb_q[$];

    mem_block_if #(.PA_WIDTH(32), .MEM_WIDTH(128)) bus ();

    mem_block_responder #(
        .PA_WIDTH(32), .MEM_WIDTH(128), .IDX_BITS(10), .LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.mem_ready === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got ready at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (cyc != e.acc_cyc + LAT) begin
                    n_fail++;
                    $display("FAIL ready_latency: got cycle %0d expected %0d", cyc, e.acc_cyc + LAT);
                end
                if (e.is_rd) check("rd_data", bus.mem_rd_blk, e.data);
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [127:0] wdata, input logic [127:0] exp_rd, input bit track);
        exp_t e;
        @(negedge clk);
        bus.mem_addr   = addr;
        bus.mem_rd_en  = rd;
        bus.mem_wr_en  = wr;
        bus.mem_wr_blk = wdata;
        @(posedge clk);
        #1;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        check("busy_after_accept", 128'(bus.mem_busy), 128'd1);
        if (track) begin
            e.acc_cyc = cyc;
            e.is_rd   = rd && !wr;
            e.data    = exp_rd;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL ready_timeout: got %0d outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    localparam logic [127:0] D1   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] DAA  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [127:0] DC   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] DD   = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] DOLD = 128'h0BAD0BAD_F00DF00D_12345678_9ABCDEF0;
    localparam logic [127:0] DNEW = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

    initial begin
        bus.mem_addr   = '0;
        bus.mem_rd_en  = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_wr_blk = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",  128'(bus.mem_busy),  128'd0);
        check("reset_ready", 128'(bus.mem_ready), 128'd0);
        check("reset_err",   128'(bus.mem_err),   128'd0);
        check("reset_rdblk", bus.mem_rd_blk,      128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back the same block.
        issue(32'h40, 0, 1, D1, '0, 1);
        wait_done();
        issue(32'h40, 1, 0, '0, D1, 1);
        wait_done();
        // A write must leave the held read data untouched.
        issue(32'h80, 0, 1, DC, '0, 1);
        wait_done();
        check("rdblk_held_after_wr", bus.mem_rd_blk, D1);

        // Simultaneous rd+wr: write wins, error goes sticky.
        issue(32'h50, 1, 1, DAA, '0, 1);
        wait_done();
        check("err_set", 128'(bus.mem_err), 128'd1);
        issue(32'h50, 1, 0, '0, DAA, 1);
        wait_done();
        check("err_sticky", 128'(bus.mem_err), 128'd1);

        // Request driven while busy is ignored.
        issue(32'h10, 0, 1, DC, '0, 1);
        wait_done();
        issue(32'h20, 0, 1, DD, '0, 1);
        wait_done();
        issue(32'h10, 1, 0, '0, DC, 1);
        @(negedge clk);
        bus.mem_addr  = 32'h20;
        bus.mem_rd_en = 1'b1;
        @(negedge clk);
        bus.mem_rd_en = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Reset in flight discards the write.
        issue(32'h60, 0, 1, DOLD, '0, 1);
        wait_done();
        issue(32'h60, 0, 1, DNEW, '0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(bus.mem_busy), 128'd0);
        check("rst_err",  128'(bus.mem_err),  128'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_ready", 128'(bus.mem_ready), 128'd0);
        end
        rst_n = 1'b1;
        issue(32'h60, 1, 0, '0, DOLD, 1);
        wait_done();

`ifdef MEM_INIT_PATTERN_EN
        issue(32'h30, 1, 0, '0, {4{32'h00000003}}, 1);
        wait_done();
        issue(32'h4030, 1, 0, '0, {4{32'h00000003}}, 1);
        wait_done();
`endif
        // Index aliasing: upper address bits select the same block as 0x40.
        issue(32'h8000_4040, 1, 0, '0, D1, 1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
